// File: rtl/branch_resolve_bht.sv
// Execute-stage branch resolution with a 2-bit saturating-counter BHT and registered redirect.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve_bht #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    output logic             branch_taken,
`ifdef BRANCH_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts,
`endif
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);

    localparam int IDX_W = $clog2(DEPTH);

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up)
            return (cnt == 2'd3) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    endfunction

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic                   cond;
    logic                   legal;
    logic                   res;
    logic                   mis;
    logic [IDX_W-1:0]       ex_idx;
    logic [IDX_W-1:0]       if_idx;
    logic [1:0]             bht_q [DEPTH];
    logic [1:0]             cnt_d;
    logic                   redirect_valid_q;
    logic                   redirect_valid_d;
    logic [XLEN-1:0]        redirect_pc_q;
    logic [XLEN-1:0]        redirect_pc_d;
    logic                   if_pc_unused;

    assign rs1_s  = ex_rs1;
    assign rs2_s  = ex_rs2;
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_pc_unused = ^{if_pc[1:0], if_pc[XLEN-1:IDX_W+2]};

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = (rs1_s < rs2_s);
            3'b101:  cond = (rs1_s >= rs2_s);
            3'b110:  cond = (ex_rs1 < ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: legal = 1'b0;
        endcase
    end

    assign branch_taken  = ex_valid & cond;
    assign res           = ex_valid & ~ex_stall & legal;
    assign mis           = res & (branch_taken != ex_pred_taken);
    // Read is the registered table value, so a same-cycle update is not bypassed.
    assign if_pred_taken = bht_q[if_idx][1];
    assign cnt_d         = sat_step(bht_q[ex_idx], branch_taken);

    always_comb begin
        redirect_valid_d = mis;
        redirect_pc_d    = redirect_pc_q;
        if (mis)
            redirect_pc_d = branch_taken ? ex_target : ex_pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                bht_q[i] <= 2'd1;
        end else if (res) begin
            bht_q[ex_idx] <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] perf_br_q;
    logic [CNT_W-1:0] perf_mis_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            if (res)
                perf_br_q <= perf_br_q + CNT_W'(1);
            if (mis)
                perf_mis_q <= perf_mis_q + CNT_W'(1);
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mis_q;
`else
    logic perf_unused;
    assign perf_unused = |CNT_W;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Randomized self-checking bench for branch_resolve_bht against a behavioural model.
// Builds with or without BRANCH_PERF_CNT_EN.
module tb_branch_resolve_bht;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [XLEN-1:0]   if_pc;
    logic              if_pred_taken;
    logic              ex_valid;
    logic              ex_stall;
    logic [2:0]        ex_funct3;
    logic [XLEN-1:0]   ex_rs1;
    logic [XLEN-1:0]   ex_rs2;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_target;
    logic              ex_pred_taken;
    logic              branch_taken;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0]  perf_branches;
    logic [CNT_W-1:0]  perf_mispredicts;
`endif

    branch_resolve_bht #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_funct3        (ex_funct3),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .branch_taken     (branch_taken),
`ifdef BRANCH_PERF_CNT_EN
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts),
`endif
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int          m_bht [DEPTH];
    logic        m_rv;
    logic [31:0] m_rpc;
    int          m_pb;
    int          m_pm;
    bit          m_ok = 0;
    int          pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint as_signed(input logic [31:0] v);
        return (v >= 32'h8000_0000) ? longint'(v) - 64'sd4294967296 : longint'(v);
    endfunction

    function automatic bit is_legal(input logic [2:0] f);
        return !(f == 3'd2 || f == 3'd3);
    endfunction

    function automatic bit outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (f)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return as_signed(a) < as_signed(b);
            3'd5:    return as_signed(a) >= as_signed(b);
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    // One clock: check combinational outputs, advance the model on the edge, check registered outputs.
    task automatic cycle();
        bit exp_t, r, mis;
        #3;
        exp_t = ex_valid && outcome(ex_funct3, ex_rs1, ex_rs2);
        check("branch_taken", 32'(branch_taken), 32'(exp_t));
        if (m_ok)
            check("if_pred", 32'(if_pred_taken), 32'(m_bht[idx_of(if_pc)] >= 2));
        r   = ex_valid && !ex_stall && is_legal(ex_funct3);
        mis = r && (exp_t != ex_pred_taken);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
            m_rv = 0; m_rpc = 0; m_pb = 0; m_pm = 0; m_ok = 1;
        end else if (m_ok) begin
            if (r) begin
                if (exp_t) m_bht[idx_of(ex_pc)] = (m_bht[idx_of(ex_pc)] == 3) ? 3 : m_bht[idx_of(ex_pc)] + 1;
                else       m_bht[idx_of(ex_pc)] = (m_bht[idx_of(ex_pc)] == 0) ? 0 : m_bht[idx_of(ex_pc)] - 1;
                m_pb = (m_pb + 1) % (1 << CNT_W);
            end
            m_rv = mis;
            if (mis) begin
                m_rpc = exp_t ? ex_target : ex_pc + 32'd4;
                m_pm = (m_pm + 1) % (1 << CNT_W);
            end
        end
        #1;
        if (m_ok) begin
            check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
            check("redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_PERF_CNT_EN
            check("perf_branches", 32'(perf_branches), 32'(m_pb));
            check("perf_mispredicts", 32'(perf_mispredicts), 32'(m_pm));
`endif
        end
        if (redirect_valid === 1'b1) pulses++;
    endtask

    task automatic drive(input bit v, input bit s, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                         input bit pred);
        ex_valid = v; ex_stall = s; ex_funct3 = f; ex_rs1 = a; ex_rs2 = b;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    task automatic idle();
        drive(0, 0, 3'd0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        rst = 1; if_pc = 32'h100; idle();
        cycle();
        rst = 0;
        check("reset_rv", 32'(redirect_valid), 32'd0);
        check("reset_rpc", redirect_pc, 32'd0);

        // BEQ mispredicted as not-taken
        #3; check("reset_pred_100", 32'(if_pred_taken), 32'd0); #0;
        drive(1, 0, 3'd0, 5, 5, 32'h100, 32'h80, 0);
        cycle();
        check("beq_rv", 32'(redirect_valid), 32'd1);
        check("beq_rpc", redirect_pc, 32'h80);
        idle(); cycle();
        check("beq_pulse_end", 32'(redirect_valid), 32'd0);
        check("beq_pred_now", 32'(if_pred_taken), 32'd1);

        // Signed vs unsigned compares
        drive(1, 0, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 32'h300, 1); cycle();
        check("bltu_rpc", redirect_pc, 32'h204);
        drive(1, 0, 3'd4, 32'hFFFF_FFFF, 1, 32'h204, 32'h300, 0); cycle();
        drive(1, 0, 3'd7, 32'hFFFF_FFFF, 1, 32'h208, 32'h300, 1); cycle();
        drive(1, 0, 3'd5, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 32'h300, 1); cycle();
        check("pc_wrap_rpc", redirect_pc, 32'h0);

        // Saturation then decay at one PC
        if_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin drive(1, 0, 3'd1, 1, 2, 32'h40, 32'h10, 1); cycle(); end
        drive(1, 0, 3'd1, 3, 3, 32'h40, 32'h10, 1); cycle();
        idle(); #3; check("decay1_pred", 32'(if_pred_taken), 32'd1); #0;
        drive(1, 0, 3'd1, 3, 3, 32'h40, 32'h10, 1); cycle();
        idle(); #3; check("decay2_pred", 32'(if_pred_taken), 32'd0); #0;
        cycle();

        // Stall for three cycles then release: one pulse only
        pulses = 0;
        drive(1, 1, 3'd0, 7, 7, 32'h500, 32'h600, 0);
        for (int i = 0; i < 3; i++) cycle();
        ex_stall = 0; cycle();
        idle(); cycle(); cycle();
        check("stall_pulses", 32'(pulses), 32'd1);

        // Illegal funct3 has no effect
        drive(1, 0, 3'd2, 7, 7, 32'h40, 32'h600, 1); cycle();
        check("f3_010_rv", 32'(redirect_valid), 32'd0);

        // Reset wins over a simultaneous mispredict
        drive(1, 0, 3'd0, 1, 1, 32'h700, 32'h900, 0); if_pc = 32'h100; rst = 1; cycle();
        rst = 0; idle();
        check("rst_rv", 32'(redirect_valid), 32'd0);
        #3; check("rst_pred", 32'(if_pred_taken), 32'd0); #0;
        cycle();

`ifdef BRANCH_PERF_CNT_EN
        for (int i = 0; i < 16; i++) begin drive(1, 0, 3'd0, 1, 1, 32'h20, 32'h0, 1); cycle(); end
        idle(); cycle();
        check("perf_wrap", 32'(perf_branches), 32'd0);
`endif

        // Randomized traffic including back-to-back mispredicts
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            if_pc = {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                  pick_op(), pick_op(), {$urandom_range(0, 127), 2'b00} | ($urandom_range(0, 7) == 0 ? 32'hFFFF_FF00 : 32'h0),
                  $urandom(), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ex_rs2 = ex_rs1;
            cycle();
        end
        rst = 0; idle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
